// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: round-robin sharing of one combinational-read instruction memory
// among NUM_PORTS fetch requesters, with a registered one-cycle response pulse per fetch.
module imem_fetch_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   req_valid,
    input  logic [NUM_PORTS*32-1:0] req_addr,
    output logic [NUM_PORTS-1:0]   req_ready,
    output logic [NUM_PORTS-1:0]   resp_valid,
    output logic [NUM_PORTS*32-1:0] resp_data,
    output logic [31:0]            mem_addr,
    input  logic [31:0]            mem_read_data
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t         state, state_nx;
    logic [PW-1:0]  rr_ptr, grant_q, win;
    logic [31:2]    addr_q;
    logic [3:0]     wait_cnt;
    logic           found;
    logic           last_wait;

    assign last_wait  = wait_cnt == 4'(WAIT_CYCLES);
    assign mem_addr   = {addr_q, 2'b00};
    assign resp_valid = (state == RESP) ? (NUM_PORTS'(1) << grant_q) : '0;
    assign req_ready  = found ? (NUM_PORTS'(1) << win) : '0;

    // First requesting port at or after rr_ptr wins; no grants while an access is in flight.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && state != ACCESS && req_valid[(int'(rr_ptr) + k) % NUM_PORTS]) begin
                found = 1'b1;
                win   = PW'((int'(rr_ptr) + k) % NUM_PORTS);
            end
        end
        state_nx = (state == ACCESS) ? (last_wait ? RESP : ACCESS) : (found ? ACCESS : IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            wait_cnt  <= '0;
            resp_data <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state == ACCESS && !last_wait) ? wait_cnt + 4'd1 : 4'd0;
            if (found) begin
                addr_q  <= req_addr[32*win+2 +: 30];
                grant_q <= win;
                rr_ptr  <= (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
            end
            if (state == ACCESS && last_wait)
                resp_data[32*grant_q +: 32] <= mem_read_data;
        end
    end
endmodule
